ita_output_writer: RTL

- Consumer end of the datapath output stream (oup_valid/oup_ready) whose handshakes the controller counts to track in-flight tiles.
- Accepts one N-lane output beat per handshake and computes its destination byte address from the tile order.
- Masks padded lanes and rows for partial tiles, and issues one registered memory write request per valid beat.
- Sits between the requantizer output and the L1 write port.

---
 rtl/ita_output_writer_if.sv | 30 +++
 rtl/ita_output_writer.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/ita_output_writer_if.sv
`default_nettype none
// ============================================================================
// ita_output_writer_if : output-beat stream plus L1 write-request bus
// Rev 1.0
// ============================================================================
interface ita_output_writer_if #(
  parameter int N  = 16,
  parameter int DW = 8,
  parameter int AW = 32
);
  logic              oup_valid;
  logic              oup_ready;
  logic [N*DW-1:0]   oup_data;
  logic              mem_req;
  logic              mem_gnt;
  logic [AW-1:0]     mem_addr;
  logic [N*DW-1:0]   mem_data;
  logic [N*DW/8-1:0] mem_be;

  // master: beat producer and memory port; slave: the writer itself
  modport master (
    output oup_valid, oup_data, mem_gnt,
    input  oup_ready, mem_req, mem_addr, mem_data, mem_be
  );
  modport slave (
    input  oup_valid, oup_data, mem_gnt,
    output oup_ready, mem_req, mem_addr, mem_data, mem_be
  );
endinterface
`default_nettype wire

// File: rtl/ita_output_writer.sv
`default_nettype none
// ============================================================================
// ita_output_writer : maps tiled output beats to masked L1 write requests
// Rev 1.0
// ============================================================================
module ita_output_writer #(
  parameter int N  = 16,
  parameter int M  = 64,
  parameter int DW = 8,
  parameter int AW = 32,
  parameter int CW = 16
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               start_i,
  input  logic [AW-1:0]      base_addr_i,
  input  logic [AW-1:0]      row_stride_i,
  input  logic [CW-1:0]      rows_i,
  input  logic [CW-1:0]      cols_i,
  output logic               busy_o,
  output logic               done_o,
  ita_output_writer_if.slave bus
);
  localparam int LOG_M = $clog2(M);
  localparam int LOG_N = $clog2(N);
  localparam int BPT   = M * M / N;
  localparam int BW    = $clog2(BPT);
  localparam int PW    = CW + LOG_M;
  localparam int BPL   = DW / 8;
  localparam int BEW   = N * BPL;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t state, state_nxt;

  logic [AW-1:0]   cfg_base, cfg_stride;
  logic [CW-1:0]   cfg_rows, cfg_cols, tx_max, ty_max;
  logic [BW-1:0]   beat;
  logic [CW-1:0]   tile_x, tile_y;
  logic            req_q;
  logic [AW-1:0]   addr_q;
  logic [N*DW-1:0] data_q;
  logic [BEW-1:0]  be_q;

  logic [CW:0]     rows_up, cols_up;
  logic [CW-1:0]   ty_max_nxt, tx_max_nxt;
  logic            beat_last, tx_last, ty_last, mat_last;
  logic [LOG_M-1:0] col_off;
  logic [PW-1:0]   row, col;
  logic            dropped, ready, fire, load_cfg;
  logic [AW-1:0]   addr_w;
  logic [BEW-1:0]  be_w;

  // tile counts are ceil(x/M), kept as count-1 for the wrap compares
  assign rows_up    = {1'b0, rows_i} + (CW+1)'(M - 1);
  assign cols_up    = {1'b0, cols_i} + (CW+1)'(M - 1);
  assign ty_max_nxt = CW'(rows_up >> LOG_M) - CW'(1);
  assign tx_max_nxt = CW'(cols_up >> LOG_M) - CW'(1);

  assign beat_last = (beat == BW'(BPT - 1));
  assign tx_last   = (tile_x == tx_max);
  assign ty_last   = (tile_y == ty_max);
  assign mat_last  = beat_last && tx_last && ty_last;

  // beats walk down a column strip first: low beat bits pick the row
  assign col_off = LOG_M'(beat >> LOG_M) << LOG_N;
  assign row     = (PW'(tile_y) << LOG_M) | PW'(beat[LOG_M-1:0]);
  assign col     = (PW'(tile_x) << LOG_M) | PW'(col_off);
  assign dropped = (row >= PW'(cfg_rows)) || (col >= PW'(cfg_cols));
  assign addr_w  = cfg_base + AW'(row) * cfg_stride + AW'(col) * AW'(BPL);

  for (genvar i = 0; i < N; i++) begin : g_lane
    logic lane_en;
    assign lane_en = ({1'b0, col} + (PW+1)'(i)) < {1'b0, PW'(cfg_cols)};
    assign be_w[i*BPL +: BPL] = {BPL{lane_en}};
  end

  assign ready         = (state == S_RUN) && (!req_q || bus.mem_gnt);
  assign fire          = bus.oup_valid && ready;
  assign bus.oup_ready = ready;
  assign bus.mem_req   = req_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_data  = data_q;
  assign bus.mem_be    = be_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy_o    = 1'b0;
    done_o    = 1'b0;
    load_cfg  = 1'b0;
    case (state)
      S_IDLE: begin
        if (start_i) begin
          load_cfg  = 1'b1;
          state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        busy_o = 1'b1;
        if (fire && mat_last) state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        busy_o = 1'b1;
        if (!req_q || bus.mem_gnt) state_nxt = S_DONE;
      end
      S_DONE: begin
        done_o    = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cfg_base   <= '0;
      cfg_stride <= '0;
      cfg_rows   <= '0;
      cfg_cols   <= '0;
      tx_max     <= '0;
      ty_max     <= '0;
      beat       <= '0;
      tile_x     <= '0;
      tile_y     <= '0;
    end else if (load_cfg) begin
      cfg_base   <= base_addr_i;
      cfg_stride <= row_stride_i;
      cfg_rows   <= rows_i;
      cfg_cols   <= cols_i;
      tx_max     <= tx_max_nxt;
      ty_max     <= ty_max_nxt;
      beat       <= '0;
      tile_x     <= '0;
      tile_y     <= '0;
    end else if (fire) begin
      if (beat_last) begin
        beat <= '0;
        if (tx_last) begin
          tile_x <= '0;
          tile_y <= tile_y + CW'(1);
        end else begin
          tile_x <= tile_x + CW'(1);
        end
      end else begin
        beat <= beat + BW'(1);
      end
    end
  end

  // single-entry request register; a grant and a new load share one edge
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      req_q  <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
      be_q   <= '0;
    end else if (fire && !dropped) begin
      req_q  <= 1'b1;
      addr_q <= addr_w;
      data_q <= bus.oup_data;
      be_q   <= be_w;
    end else if (req_q && bus.mem_gnt) begin
      req_q  <= 1'b0;
    end
  end
endmodule
`default_nettype wire
